// File: rtl/rot13_drv_pkg.sv
// Shared types and helpers for the ROT13 byte driver: FSM states, translate-stage
// control codes and the letter classifier.
package rot13_drv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_XL,
        ST_WAIT,
        ST_OUT
    } state_t;

    localparam logic [1:0] CTL_LOW_NIBBLE  = 2'b00;
    localparam logic [1:0] CTL_HIGH_NIBBLE = 2'b01;
    localparam logic [1:0] CTL_TRANSLATE   = 2'b10;

    function automatic logic is_alpha(input logic [7:0] b);
        return ((b >= 8'h41) && (b <= 8'h5A)) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

endpackage

// File: rtl/rot13_byte_driver.sv
// Sequences whole bytes through the nibble-serial ROT13 stage and returns results
// on a valid/ready stream. Optional ROT13_PASSTHRU_NONALPHA_EN forwards non-letters directly.
module rot13_byte_driver
    import rot13_drv_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       dut_ctl,
    output logic [3:0]       dut_data,
    input  logic [7:0]       dut_result,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] byte_count
);

    localparam int WAIT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        latched;
    logic [WAIT_W-1:0] wait_cnt;
    logic              accept;
    logic [7:0]        capture_val;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;

`ifdef ROT13_PASSTHRU_NONALPHA_EN
    // Non-letters ride through WAIT with a zero count so they surface one edge after accept.
    logic passthru;
    assign capture_val = passthru ? latched : dut_result;
`else
    assign capture_val = dut_result;
`endif

    always_comb begin
        state_nxt = state;
        dut_ctl   = CTL_TRANSLATE;
        dut_data  = latched[3:0];
        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef ROT13_PASSTHRU_NONALPHA_EN
                    state_nxt = is_alpha(in_byte) ? ST_LO : ST_WAIT;
`else
                    state_nxt = ST_LO;
`endif
                end
            end
            ST_LO: begin
                dut_ctl   = CTL_LOW_NIBBLE;
                dut_data  = latched[3:0];
                state_nxt = ST_HI;
            end
            ST_HI: begin
                dut_ctl   = CTL_HIGH_NIBBLE;
                dut_data  = latched[7:4];
                state_nxt = ST_XL;
            end
            ST_XL: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            latched    <= 8'h00;
            wait_cnt   <= '0;
            out_byte   <= 8'h00;
            out_valid  <= 1'b0;
            byte_count <= '0;
`ifdef ROT13_PASSTHRU_NONALPHA_EN
            passthru   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        latched  <= in_byte;
                        wait_cnt <= '0;
`ifdef ROT13_PASSTHRU_NONALPHA_EN
                        passthru <= !is_alpha(in_byte);
`endif
                    end
                end
                ST_XL: begin
                    wait_cnt <= WAIT_W'(SETTLE_CYCLES - 1);
                end
                ST_WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end else begin
                        out_byte  <= capture_val;
                        out_valid <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        byte_count <= byte_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rot13_byte_driver.sv
// Bench for rot13_byte_driver paired with a behavioural nibble-serial translate stage;
// vector table, hand-written corner sequences and a randomized run against a ROT13 model.
module tb_rot13_byte_driver;
    import rot13_drv_pkg::*;

    localparam int SETTLE = 1;
    localparam int CW     = 8;
`ifdef ROT13_PASSTHRU_NONALPHA_EN
    localparam bit PASS = 1'b1;
`else
    localparam bit PASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    in_byte;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    dut_ctl;
    logic [3:0]    dut_data;
    logic [7:0]    dut_result;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] byte_count;

    int            n_checks = 0;
    int            n_err    = 0;
    logic [CW-1:0] exp_cnt;

    always #5 clk = ~clk;

    rot13_byte_driver #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .dut_ctl(dut_ctl), .dut_data(dut_data),
        .dut_result(dut_result), .out_byte(out_byte), .out_valid(out_valid),
        .out_ready(out_ready), .byte_count(byte_count)
    );

    // Stand-in for the translate stage: nibble load registers plus a registered result.
    logic [3:0] st_lo, st_hi;
    logic [7:0] st_res;

    function automatic logic [7:0] stage_xlate(input logic [7:0] v);
        if ((v >= "A" && v <= "M") || (v >= "a" && v <= "m")) return v + 8'd13;
        if ((v >= "N" && v <= "Z") || (v >= "n" && v <= "z")) return v - 8'd13;
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            st_lo <= 4'h0; st_hi <= 4'h0; st_res <= 8'h00;
        end else begin
            case (dut_ctl)
                2'b00:   st_lo  <= dut_data;
                2'b01:   st_hi  <= dut_data;
                2'b10:   st_res <= stage_xlate({st_hi, st_lo});
                default: ;
            endcase
        end
    end
    assign dut_result = st_res;

    function automatic logic [7:0] ref_rot13(input logic [7:0] b);
        int base;
        if (!is_alpha(b)) return PASS ? b : 8'h00;
        base = (b < 8'h61) ? 65 : 97;
        return 8'(base + (int'(b) - base + 13) % 26);
    endfunction

    function automatic int ref_lat(input logic [7:0] b);
        if (PASS && !is_alpha(b)) return 1;
        return 3 + SETTLE;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_byte(input string nm, input logic [7:0] b, input logic [7:0] exp,
                           input int exp_lat, input int stall);
        int   k;
        int   lat;
        logic moved;
        in_byte  = b;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin tick; k++; end
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
        moved    = (dut_ctl != CTL_TRANSLATE);
        lat = 0;
        while (!out_valid && lat < 40) begin
            out_ready = 1'($urandom_range(0, 1));
            tick;
            lat++;
            if (dut_ctl != CTL_TRANSLATE) moved = 1'b1;
        end
        out_ready = 1'b0;
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " out_byte"}, 32'(out_byte), 32'(exp));
        if (PASS && !is_alpha(b)) chk({nm, " ctl_moved"}, 32'(moved), 32'd0);
        for (int i = 0; i < stall; i++) begin
            tick;
            chk({nm, " hold_valid"}, 32'(out_valid), 32'd1);
            chk({nm, " hold_byte"}, 32'(out_byte), 32'(exp));
        end
        // A byte offered during the output handshake must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_byte   = 8'h41;
        tick;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        exp_cnt   = exp_cnt + CW'(1);
        chk({nm, " count"}, 32'(byte_count), 32'(exp_cnt));
        chk({nm, " valid_drop"}, 32'(out_valid), 32'd0);
        chk({nm, " idle_after"}, 32'(in_ready), 32'd1);
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;
    vec_t tbl[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rb;
        tbl[0]  = '{8'h61, 8'h6E};
        tbl[1]  = '{8'h41, 8'h4E};
        tbl[2]  = '{8'h5A, 8'h4D};
        tbl[3]  = '{8'h7A, 8'h6D};
        tbl[4]  = '{8'h6E, 8'h61};
        tbl[5]  = '{8'h4E, 8'h41};
        tbl[6]  = '{8'h4D, 8'h5A};
        tbl[7]  = '{8'h6D, 8'h7A};
        tbl[8]  = '{8'h21, PASS ? 8'h21 : 8'h00};
        tbl[9]  = '{8'h40, PASS ? 8'h40 : 8'h00};
        tbl[10] = '{8'h5B, PASS ? 8'h5B : 8'h00};
        tbl[11] = '{8'h60, PASS ? 8'h60 : 8'h00};
        tbl[12] = '{8'h7B, PASS ? 8'h7B : 8'h00};
        tbl[13] = '{8'h00, 8'h00};
        tbl[14] = '{8'hFF, PASS ? 8'hFF : 8'h00};

        // Reset held with a byte offered; nothing may be taken.
        reset = 1'b0; in_valid = 1'b1; in_byte = 8'h41; out_ready = 1'b0;
        exp_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst count", 32'(byte_count), 32'd0);
        chk("rst ctl", 32'(dut_ctl), 32'(CTL_TRANSLATE));
        chk("rst data", 32'(dut_data), 32'd0);
        chk("rst out_byte", 32'(out_byte), 32'd0);
        reset = 1'b1; in_valid = 1'b0;
        tick;

        // 'a' with its control/data sequence and consumer always ready.
        in_byte = 8'h61; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("a ctl_lo", 32'(dut_ctl), 32'(CTL_LOW_NIBBLE));
        chk("a data_lo", 32'(dut_data), 32'h1);
        tick;
        chk("a ctl_hi", 32'(dut_ctl), 32'(CTL_HIGH_NIBBLE));
        chk("a data_hi", 32'(dut_data), 32'h6);
        tick;
        chk("a ctl_xl", 32'(dut_ctl), 32'(CTL_TRANSLATE));
        chk("a valid_early", 32'(out_valid), 32'd0);
        tick;
        chk("a valid_early2", 32'(out_valid), 32'd0);
        tick;
        chk("a valid", 32'(out_valid), 32'd1);
        chk("a out_byte", 32'(out_byte), 32'h6E);
        tick;
        out_ready = 1'b0;
        exp_cnt = exp_cnt + CW'(1);
        chk("a count", 32'(byte_count), 32'(exp_cnt));
        chk("a valid_drop", 32'(out_valid), 32'd0);

        // Backpressure on the first of two bytes.
        do_byte("bp_4D", 8'h4D, 8'h5A, 3 + SETTLE, 5);
        do_byte("bp_7A", 8'h7A, 8'h6D, 3 + SETTLE, 0);

        for (int i = 0; i < 15; i++) begin
            do_byte($sformatf("vec%0d", i), tbl[i].din, tbl[i].dout, ref_lat(tbl[i].din), i % 3);
        end

        // Reset while the high nibble is being loaded.
        in_byte = 8'h41; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        chk("midrst in_hi", 32'(dut_ctl), 32'(CTL_HIGH_NIBBLE));
        reset = 1'b0;
        tick;
        reset = 1'b1;
        exp_cnt = '0;
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst count", 32'(byte_count), 32'd0);
        chk("midrst ctl", 32'(dut_ctl), 32'(CTL_TRANSLATE));
        do_byte("midrst 41", 8'h41, 8'h4E, 3 + SETTLE, 0);

        // Randomized run long enough to wrap the byte counter.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 1)
                rb = 8'($urandom_range(0, 1) == 1 ? $urandom_range(65, 90) : $urandom_range(97, 122));
            else
                rb = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 2)) tick;
            do_byte($sformatf("rnd%0d", n), rb, ref_rot13(rb), ref_lat(rb), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
